// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 search pipeline front end.
package md5_pkg;

    localparam int BLOCK_BYTES   = 64;
    localparam int LEN_OFFSET    = 56;
    localparam int MAX_MSG_BYTES = 55;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef logic [8*BLOCK_BYTES-1:0] md5_block_t;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } builder_state_t;

    // ASCII character for one BCD digit ('0' is 0x30)
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
        return {4'h3, digit};
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Decimal nonce counter: DIGITS BCD digits (digit i is the 10^i place) plus
// a count of significant digits. Loads START on reset or load, steps by one
// on inc, and flags the all-nines value so the caller can stop before wrap.
module bcd_counter #(
    parameter int DIGITS = 8,
    parameter int START  = 1,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   digits,
    output logic [CW-1:0]         num_digits,
    output logic                  all_nines
);

    logic [4*DIGITS-1:0] digits_r;
    logic [4*DIGITS-1:0] digits_nx_s;
    logic [CW-1:0]       count_r;
    logic [CW-1:0]       count_nx_s;
    logic                low_nines_s;
    logic                carry_s;

    // BCD image of START, built at elaboration
    function automatic logic [4*DIGITS-1:0] start_digits();
        logic [4*DIGITS-1:0] d;
        int unsigned         v;
        d = '0;
        v = START;
        for (int i = 0; i < DIGITS; i++) begin
            d[4*i +: 4] = 4'(v % 32'd10);
            v = v / 32'd10;
        end
        return d;
    endfunction

    // Significant digits of START (zero still counts as one digit)
    function automatic logic [CW-1:0] start_count();
        int n;
        n = 1;
        for (int i = 1; i < DIGITS; i++) begin
            if (START >= 32'd10 ** i) begin
                n = i + 1;
            end
        end
        return CW'(n);
    endfunction

    // Ripple increment and digit-count growth when the low digits are all nines
    always_comb begin
        digits_nx_s = digits_r;
        carry_s     = 1'b1;
        low_nines_s = 1'b1;
        all_nines   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry_s) begin
                if (digits_r[4*i +: 4] == 4'd9) begin
                    digits_nx_s[4*i +: 4] = 4'd0;
                end else begin
                    digits_nx_s[4*i +: 4] = digits_r[4*i +: 4] + 4'd1;
                    carry_s = 1'b0;
                end
            end else begin
                digits_nx_s[4*i +: 4] = digits_r[4*i +: 4];
            end
            if (CW'(i) < count_r) begin
                low_nines_s = low_nines_s & (digits_r[4*i +: 4] == 4'd9);
            end else begin
                low_nines_s = low_nines_s;
            end
            all_nines = all_nines & (digits_r[4*i +: 4] == 4'd9);
        end
        if (low_nines_s && (count_r < CW'(DIGITS))) begin
            count_nx_s = count_r + CW'(1);
        end else begin
            count_nx_s = count_r;
        end
    end

    // Digit and length registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits_r <= start_digits();
            count_r  <= start_count();
        end else if (load) begin
            digits_r <= start_digits();
            count_r  <= start_count();
        end else if (inc) begin
            digits_r <= digits_nx_s;
            count_r  <= count_nx_s;
        end
    end

    assign digits     = digits_r;
    assign num_digits = count_r;

endmodule

// File: rtl/md5_block_builder.sv
// MD5 message block builder: stores an ASCII key, then emits one padded
// 512-bit block of key || decimal(nonce) per handshake until stopped or the
// nonce range runs out.
// Optional feature: define MD5_BUILDER_NONCE_EN to add a binary copy of the
// nonce on block_nonce.
module md5_block_builder
    import md5_pkg::*;
#(
    parameter int MAX_KEY_LEN  = 16,
    parameter int NONCE_DIGITS = 8,
    parameter int START_NONCE  = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         key_valid,
    input  logic [7:0]   key_byte,
    input  logic         key_last,
    input  logic         stop,
    output logic         block_valid,
    input  logic         block_ready,
    output md5_block_t   block_data,
`ifdef MD5_BUILDER_NONCE_EN
    output logic [31:0]  block_nonce,
`endif
    output logic         done,
    output logic         overflow,
    output logic         key_error
);

    localparam int KW = $clog2(MAX_KEY_LEN + 1);
    localparam int CW = $clog2(NONCE_DIGITS + 1);

    if (MAX_KEY_LEN + NONCE_DIGITS > MAX_MSG_BYTES) begin : g_len_check
        $error("md5_block_builder: key plus nonce digits exceed one block");
    end

    builder_state_t          state_r;
    builder_state_t          state_nx_s;
    logic [7:0]              key_mem_r [MAX_KEY_LEN];
    logic [KW-1:0]           key_len_r;
    logic                    key_error_r;
    logic                    block_valid_r;
    logic                    done_r;
    logic                    overflow_r;
    logic                    overflow_nx_s;
    logic                    fire_s;
    logic                    inc_s;
    logic                    load_s;
    logic [4*NONCE_DIGITS-1:0] digits_s;
    logic [CW-1:0]           num_digits_s;
    logic                    all_nines_s;
    md5_block_t              block_s;
    int                      key_len_v;
    int                      dig_cnt_v;
    int                      pos_v;
    int                      msg_len_v;

    assign fire_s = (state_r == ST_RUN) && block_ready;
    assign inc_s  = fire_s && !stop && !all_nines_s;
    assign load_s = (state_r == ST_LOAD);

    bcd_counter #(
        .DIGITS (NONCE_DIGITS),
        .START  (START_NONCE),
        .CW     (CW)
    ) u_nonce (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load_s),
        .inc        (inc_s),
        .digits     (digits_s),
        .num_digits (num_digits_s),
        .all_nines  (all_nines_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state: stop wins over a same-cycle handshake; accepting the
    // all-nines nonce ends the search with overflow
    always_comb begin
        state_nx_s    = state_r;
        overflow_nx_s = overflow_r;
        case (state_r)
            ST_LOAD: begin
                if (key_valid && key_last) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nx_s = ST_DONE;
                end else if (fire_s && all_nines_s) begin
                    state_nx_s    = ST_DONE;
                    overflow_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_DONE;
            end
            default: begin
                state_nx_s = ST_LOAD;
            end
        endcase
    end

    // Registered status flags, derived from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            block_valid_r <= 1'b0;
            done_r        <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            block_valid_r <= (state_nx_s == ST_RUN);
            done_r        <= (state_nx_s == ST_DONE);
            overflow_r    <= overflow_nx_s;
        end
    end

    // Key capture in LOAD; bytes beyond capacity are dropped and flagged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_len_r   <= '0;
            key_error_r <= 1'b0;
            for (int i = 0; i < MAX_KEY_LEN; i++) begin
                key_mem_r[i] <= 8'h00;
            end
        end else if ((state_r == ST_LOAD) && key_valid) begin
            if (key_len_r < KW'(MAX_KEY_LEN)) begin
                for (int i = 0; i < MAX_KEY_LEN; i++) begin
                    if (key_len_r == KW'(i)) begin
                        key_mem_r[i] <= key_byte;
                    end
                end
                key_len_r <= key_len_r + KW'(1);
            end else begin
                key_error_r <= 1'b1;
            end
        end
    end

    // Block assembly from registers only: key, digits MSB first, pad, length
    always_comb begin
        block_s   = '0;
        key_len_v = int'(key_len_r);
        dig_cnt_v = int'(num_digits_s);
        msg_len_v = key_len_v + dig_cnt_v;
        pos_v     = key_len_v;
        for (int p = 0; p < MAX_KEY_LEN; p++) begin
            block_s[8*p +: 8] = (p < key_len_v) ? key_mem_r[p] : 8'h00;
        end
        for (int j = 0; j < NONCE_DIGITS; j++) begin
            if (j < dig_cnt_v) begin
                pos_v = key_len_v + j;
                block_s[8*pos_v +: 8] =
                    bcd_to_ascii(digits_s[4*(dig_cnt_v - 1 - j) +: 4]);
            end else begin
                pos_v = msg_len_v;
            end
        end
        block_s[8*msg_len_v +: 8]  = PAD_BYTE;
        block_s[8*LEN_OFFSET +: 64] = 64'(msg_len_v * 8);
    end

`ifdef MD5_BUILDER_NONCE_EN
    logic [31:0] nonce_bin_r;

    // Binary nonce shadowing the BCD counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nonce_bin_r <= 32'(START_NONCE);
        end else if (load_s) begin
            nonce_bin_r <= 32'(START_NONCE);
        end else if (inc_s) begin
            nonce_bin_r <= nonce_bin_r + 32'd1;
        end
    end

    assign block_nonce = nonce_bin_r;
`endif

    assign block_valid = block_valid_r;
    assign block_data  = block_s;
    assign done        = done_r;
    assign overflow    = overflow_r;
    assign key_error   = key_error_r;

endmodule

// File: tb/tb_md5_block_builder.sv
// Directed bench for md5_block_builder: default instance for the main flow,
// plus a 2-digit instance starting at 97 for nonce exhaustion.
module tb_md5_block_builder;

    logic         clk = 1'b0;
    logic         reset_n, reset2_n;
    logic         key_valid, key_last, stop, stop2;
    logic [7:0]   key_byte;
    logic         block_ready, block_ready2;
    logic         block_valid, block_valid2;
    logic [511:0] block_data, block_data2;
    logic         done, done2, overflow, overflow2, key_error, key_error2;
`ifdef MD5_BUILDER_NONCE_EN
    logic [31:0]  block_nonce, block_nonce2;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    md5_block_builder dut (
        .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_byte(key_byte),
        .key_last(key_last), .stop(stop), .block_valid(block_valid),
        .block_ready(block_ready), .block_data(block_data),
`ifdef MD5_BUILDER_NONCE_EN
        .block_nonce(block_nonce),
`endif
        .done(done), .overflow(overflow), .key_error(key_error)
    );

    md5_block_builder #(.MAX_KEY_LEN(16), .NONCE_DIGITS(2), .START_NONCE(97)) dut2 (
        .clk(clk), .reset_n(reset2_n), .key_valid(key_valid), .key_byte(key_byte),
        .key_last(key_last), .stop(stop2), .block_valid(block_valid2),
        .block_ready(block_ready2), .block_data(block_data2),
`ifdef MD5_BUILDER_NONCE_EN
        .block_nonce(block_nonce2),
`endif
        .done(done2), .overflow(overflow2), .key_error(key_error2)
    );

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference block: message text, 0x80, zeros, 64-bit LE bit length
    function automatic logic [511:0] exp_block(input string key, input int nonce);
        string        msg;
        logic [511:0] b;
        msg = {key, $sformatf("%0d", nonce)};
        b = '0;
        for (int i = 0; i < msg.len(); i++) begin
            b[8*i +: 8] = msg[i];
        end
        b[8*msg.len() +: 8] = 8'h80;
        b[511:448] = 64'(msg.len() * 8);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_key(input string s);
        for (int i = 0; i < s.len(); i++) begin
            key_valid = 1'b1;
            key_byte  = s[i];
            key_last  = (i == s.len() - 1);
            tick();
        end
        key_valid = 1'b0;
        key_last  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] hand;
        reset_n = 1'b0; reset2_n = 1'b0;
        key_valid = 1'b0; key_last = 1'b0; key_byte = 8'h00;
        stop = 1'b0; stop2 = 1'b0;
        block_ready = 1'b0; block_ready2 = 1'b0;
        repeat (2) tick();

        check_val("rst_valid",    block_valid, 1'b0);
        check_val("rst_done",     done,        1'b0);
        check_val("rst_overflow", overflow,    1'b0);
        check_val("rst_key_error", key_error,  1'b0);

        reset_n = 1'b1; reset2_n = 1'b1;
        tick();
        check_val("load_valid", block_valid, 1'b0);
        feed_key("abcdef");

        // first block: "abcdef1", pad, length 56 bits
        check_val("first_valid", block_valid, 1'b1);
        hand = '0;
        hand[63:0]    = 64'h80_31_66_65_64_63_62_61;
        hand[455:448] = 8'h38;
        check_val("first_block_hand", block_data, hand);
        check_val("dut2_first", block_data2, exp_block("abcdef", 97));

        block_ready = 1'b1;
        for (int n = 1; n < 42; n++) begin
            check_val($sformatf("block_n%0d", n), block_data, exp_block("abcdef", n));
            if (n == 10) begin
                hand = '0;
                hand[71:0]    = 72'h80_30_31_66_65_64_63_62_61;
                hand[455:448] = 8'h40;
                check_val("digit_growth_hand", block_data, hand);
`ifdef MD5_BUILDER_NONCE_EN
                check_val("nonce_bin_10", block_nonce, 32'd10);
`endif
            end
            tick();
        end

        // backpressure on nonce 42
        block_ready = 1'b0;
        check_val("bp_start", block_data, exp_block("abcdef", 42));
        for (int c = 0; c < 5; c++) begin
            tick();
            check_val($sformatf("bp_hold%0d", c), block_data, exp_block("abcdef", 42));
            check_val($sformatf("bp_valid%0d", c), block_valid, 1'b1);
`ifdef MD5_BUILDER_NONCE_EN
            check_val($sformatf("bp_nonce%0d", c), block_nonce, 32'd42);
`endif
        end
        block_ready = 1'b1;
        tick();
        check_val("bp_release", block_data, exp_block("abcdef", 43));

        // asynchronous reset in RUN clears at once
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_valid", block_valid, 1'b0);
        check_val("mid_rst_done",  done,        1'b0);
        tick();
        reset_n = 1'b1;
        block_ready = 1'b0;
        tick();

        // oversize key: 18 bytes, first 16 kept, nonce restarts at 1
        feed_key("ABCDEFGHIJKLMNOPQR");
        check_val("key_error", key_error, 1'b1);
        check_val("key_trunc_block", block_data, exp_block("ABCDEFGHIJKLMNOP", 1));

        block_ready = 1'b1;
        for (int n = 1; n < 7; n++) begin
            check_val($sformatf("k2_n%0d", n), block_data, exp_block("ABCDEFGHIJKLMNOP", n));
            tick();
        end
        check_val("k2_n7", block_data, exp_block("ABCDEFGHIJKLMNOP", 7));

        // stop together with the handshake of nonce 7
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val("stop_valid",    block_valid, 1'b0);
        check_val("stop_done",     done,        1'b1);
        check_val("stop_overflow", overflow,    1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val($sformatf("stop_hold_valid%0d", c), block_valid, 1'b0);
            check_val($sformatf("stop_hold_done%0d", c),  done,        1'b1);
        end

        // 2-digit instance runs out after nonce 99
        block_ready2 = 1'b1;
        for (int n = 97; n <= 99; n++) begin
            check_val($sformatf("d2_n%0d", n), block_data2, exp_block("abcdef", n));
            check_val($sformatf("d2_valid%0d", n), block_valid2, 1'b1);
            tick();
        end
        check_val("d2_done",     done2,        1'b1);
        check_val("d2_overflow", overflow2,    1'b1);
        check_val("d2_valid",    block_valid2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
